// File: rtl/data_mem_unit_pkg.sv
// Shared types and helpers for the multi-cycle data memory unit.
package data_mem_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } memState_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  // Byte address to word index, wrapped into a power-of-2 depth.
  function automatic logic [31:0] wordIndex(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] mask;
    mask = 32'(depth - 1);
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Processor-side bus of the data memory unit.
interface data_mem_unit_if #(
  parameter int DATA_W = 32
);

  logic                MemRead;
  logic                MemWrite;
  logic [31:0]         Addr;
  logic [DATA_W-1:0]   Din;
  logic [DATA_W/8-1:0] ByteEn;
  logic [DATA_W-1:0]   Dout;
  logic                Stall;
  logic                AddrErr;
  logic                InitDone;

  modport master (
    output MemRead, MemWrite, Addr, Din, ByteEn,
    input  Dout, Stall, AddrErr, InitDone
  );

  modport slave (
    input  MemRead, MemWrite, Addr, Din, ByteEn,
    output Dout, Stall, AddrErr, InitDone
  );

endinterface

// File: rtl/data_mem_unit_array.sv
// Single-port word storage with per-byte write lanes and a registered read.
module data_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                clock,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Lane-masked write and read capture share the one address port.
  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be_i[b]) begin
          mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle data memory: clears itself after reset, then serves one
// load or store at a time with a fixed stall window and a one-cycle release.
module data_mem_unit
  import data_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic             clock,
  input logic             reset,
  data_mem_unit_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = 2;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_badLatency
    $error("data_mem_unit: LATENCY must be within 1..4");
  end
  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_badWidth
    $error("data_mem_unit: DATA_W must be a multiple of 8");
  end
  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
    $error("data_mem_unit: DEPTH must be a power of 2");
  end

  memState_e         state_q, state_d;
  logic [IDX_W-1:0]  clearIdx_q, clearIdx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              opWrite_q, opWrite_d;
  logic              opRead_q, opRead_d;
  logic              misalign_q, misalign_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              addrErr_q, addrErr_d;

  logic              stall;
  logic              arrWe;
  logic              arrRe;
  logic [IDX_W-1:0]  arrIdx;
  logic [DATA_W-1:0] arrWdata;
  logic [BE_W-1:0]   arrBe;
  logic [DATA_W-1:0] arrRdata;
  logic [IDX_W-1:0]  reqIdx;
  logic              reqMisaligned;

  assign reqIdx        = IDX_W'(wordIndex(bus.Addr, DEPTH));
  assign reqMisaligned = (bus.Addr[1:0] != 2'b00);

  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock   (clock),
    .we_i    (arrWe),
    .re_i    (arrRe),
    .idx_i   (arrIdx),
    .wdata_i (arrWdata),
    .be_i    (arrBe),
    .rdata_o (arrRdata)
  );

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      clearIdx_q <= '0;
      cnt_q      <= '0;
      opWrite_q  <= 1'b0;
      opRead_q   <= 1'b0;
      misalign_q <= 1'b0;
      idx_q      <= '0;
      din_q      <= '0;
      be_q       <= '0;
      dout_q     <= '0;
      addrErr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clearIdx_q <= clearIdx_d;
      cnt_q      <= cnt_d;
      opWrite_q  <= opWrite_d;
      opRead_q   <= opRead_d;
      misalign_q <= misalign_d;
      idx_q      <= idx_d;
      din_q      <= din_d;
      be_q       <= be_d;
      dout_q     <= dout_d;
      addrErr_q  <= addrErr_d;
    end
  end

  // Next-state, array control and handshake for clear, accept, wait and release.
  always_comb begin
    state_d    = state_q;
    clearIdx_d = clearIdx_q;
    cnt_d      = cnt_q;
    opWrite_d  = opWrite_q;
    opRead_d   = opRead_q;
    misalign_d = misalign_q;
    idx_d      = idx_q;
    din_d      = din_q;
    be_d       = be_q;
    dout_d     = dout_q;
    addrErr_d  = addrErr_q;
    stall      = 1'b1;
    arrWe      = 1'b0;
    arrRe      = 1'b0;
    arrIdx     = idx_q;
    arrWdata   = din_q;
    arrBe      = be_q;

    case (state_q)
      INIT: begin
        arrWe      = 1'b1;
        arrIdx     = clearIdx_q;
        arrWdata   = '0;
        arrBe      = '1;
        clearIdx_d = clearIdx_q + 1'b1;
        if (clearIdx_q == IDX_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        stall = bus.MemRead | bus.MemWrite;
        if (bus.MemRead | bus.MemWrite) begin
          state_d    = BUSY;
          cnt_d      = CNT_W'(LATENCY - 1);
          opWrite_d  = bus.MemWrite;
          opRead_d   = bus.MemRead & ~bus.MemWrite;
          misalign_d = reqMisaligned;
          idx_d      = reqIdx;
          din_d      = bus.Din;
          be_d       = bus.ByteEn;
          if (reqMisaligned) begin
            addrErr_d = 1'b1;
          end
          arrIdx = reqIdx;
          arrRe  = bus.MemRead & ~bus.MemWrite & ~reqMisaligned;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!misalign_q) begin
            arrWe = opWrite_q;
            if (opRead_q) begin
              dout_d = arrRdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign bus.Stall    = stall;
  assign bus.Dout     = dout_q;
  assign bus.AddrErr  = addrErr_q;
  assign bus.InitDone = (state_q != INIT);

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit with a word-level reference model.
module tb_data_mem_unit;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic clock;
  logic reset;

  data_mem_unit_if #(.DATA_W(DATA_W)) bus ();

  data_mem_unit #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          vectors;
  int          miscompares;
  bit          checkEn;
  logic        expStall;
  logic        expInitDone;
  logic        expAddrErr;
  logic [31:0] expDout;
  logic [31:0] modelMem [DEPTH];
  int          stallCnt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] din, input logic [3:0] be);
    bus.MemRead  = rd;
    bus.MemWrite = wr;
    bus.Addr     = addr;
    bus.Din      = din;
    bus.ByteEn   = be;
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
    expDout    = '0;
    expAddrErr = 1'b0;
  endtask

  // Release reset and wait out the full clear sweep.
  task automatic runInit();
    reset       = 1'b0;
    expStall    = 1'b1;
    expInitDone = 1'b0;
    repeat (DEPTH) @(posedge clock);
    #1;
    expStall    = 1'b0;
    expInitDone = 1'b1;
    #2;
    checkOutput("initDoneAfterSweep", {31'b0, bus.InitDone}, 32'h1);
  endtask

  // One request: held through the stall window and the release cycle.
  task automatic doAccess(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] din, input logic [3:0] be, output int stalls);
    bit mis;
    int idx;
    mis    = (addr[1:0] != 2'b00);
    idx    = int'((addr >> 2) % DEPTH);
    stalls = 0;
    @(posedge clock); #1;
    applyStimulus(rd, wr, addr, din, be);
    expStall = 1'b1;
    #2; if (bus.Stall) stalls++;
    for (int k = 0; k < LATENCY; k++) begin
      @(posedge clock); #1;
      if (mis) expAddrErr = 1'b1;
      #2; if (bus.Stall) stalls++;
    end
    @(posedge clock); #1;
    expStall = 1'b0;
    if (!mis) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) modelMem[idx][8*b +: 8] = din[8*b +: 8];
      end else if (rd) begin
        expDout = modelMem[idx];
      end
    end
    #2; if (bus.Stall) stalls++;
    @(posedge clock); #1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Every-cycle comparison of the DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (checkEn) begin
        checkOutput("stall",    {31'b0, bus.Stall},    {31'b0, expStall});
        checkOutput("initDone", {31'b0, bus.InitDone}, {31'b0, expInitDone});
        checkOutput("addrErr",  {31'b0, bus.AddrErr},  {31'b0, expAddrErr});
        checkOutput("dout",     bus.Dout,              expDout);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    checkEn     = 1'b0;
    reset       = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expStall    = 1'b1;
    expInitDone = 1'b0;
    clearModel();

    #2 reset = 1'b1;
    @(posedge clock); #1;
    checkEn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    runInit();

    doAccess(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, stallCnt);
    checkOutput("readAfterInit", bus.Dout, 32'h0);

    doAccess(1'b0, 1'b1, 32'h8, 32'h0000000A, 4'hF, stallCnt);
    checkOutput("writeStallCycles", stallCnt, 32'd3);
    doAccess(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, stallCnt);
    checkOutput("readStallCycles", stallCnt, 32'd3);
    checkOutput("readBack8", bus.Dout, 32'h0000000A);

    doAccess(1'b0, 1'b1, 32'hC, 32'h11223344, 4'b1111, stallCnt);
    doAccess(1'b0, 1'b1, 32'hC, 32'hAABBCCDD, 4'b0101, stallCnt);
    doAccess(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, stallCnt);
    checkOutput("byteLaneMerge", bus.Dout, 32'h11BB33DD);

    doAccess(1'b1, 1'b1, 32'h14, 32'h00000077, 4'hF, stallCnt);
    checkOutput("bothSetDoutHeld", bus.Dout, 32'h11BB33DD);
    doAccess(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, stallCnt);
    checkOutput("bothSetWrote", bus.Dout, 32'h00000077);

    doAccess(1'b0, 1'b1, 32'h400, 32'h00000005, 4'hF, stallCnt);
    doAccess(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, stallCnt);
    checkOutput("wrapRead", bus.Dout, 32'h00000005);

    doAccess(1'b1, 1'b0, 32'h6, 32'h0, 4'h0, stallCnt);
    checkOutput("misalignStallCycles", stallCnt, 32'd3);
    checkOutput("misalignDoutHeld", bus.Dout, 32'h00000005);
    checkOutput("misalignFlag", {31'b0, bus.AddrErr}, 32'h1);
    doAccess(1'b0, 1'b1, 32'h9, 32'hFFFFFFFF, 4'hF, stallCnt);
    doAccess(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, stallCnt);
    checkOutput("misalignWriteSuppressed", bus.Dout, 32'h0000000A);
    checkOutput("addrErrSticky", {31'b0, bus.AddrErr}, 32'h1);

    // Reset lands in the first BUSY cycle of a store to 0x4.
    @(posedge clock); #1;
    applyStimulus(1'b0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    expStall = 1'b1;
    @(posedge clock); #1;
    reset       = 1'b1;
    expStall    = 1'b1;
    expInitDone = 1'b0;
    clearModel();
    #2;
    checkOutput("resetAddrErrClear", {31'b0, bus.AddrErr}, 32'h0);
    @(posedge clock); #1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clock); #1;
    runInit();
    checkOutput("resetDoutZero", bus.Dout, 32'h0);
    doAccess(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, stallCnt);
    checkOutput("abortedWriteGone", bus.Dout, 32'h0);

    @(posedge clock); #1;
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
